// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: returns the 32-bit word for the IF-stage PC from a
// one-line fetch buffer on a hit, or via a valid/ready memory read on a miss.
module inst_fetch_resp #(
  parameter int ADDR_W = 64,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              inst_ena,
  input  logic              flush,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              inst_err,
  output logic              fetch_stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q;
  logic                buf_valid_q;
  logic [ADDR_W-4:0]   buf_tag_q;
  logic [LINE_W-1:0]   buf_data_q;
  logic [ADDR_W-1:0]   req_pc_q;
  logic                no_fill_q;
  logic [31:0]         inst_q;
  logic [ADDR_W-1:0]   inst_pc_q;
  logic                inst_valid_q;
  logic                inst_err_q;
  logic                hit;

  function automatic logic [31:0] sel_word(input logic [LINE_W-1:0] line, input logic hi);
    return hi ? line[63:32] : line[31:0];
  endfunction

  // A flush arriving with the request forces a miss.
  assign hit = buf_valid_q && !flush && (buf_tag_q == pc[ADDR_W-1:3]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      buf_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      no_fill_q    <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_err_q   <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      if (flush) buf_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inst_ena) begin
            if (pc[1:0] != 2'b00) begin
              inst_valid_q <= 1'b1;
              inst_err_q   <= 1'b1;
              inst_q       <= '0;
              inst_pc_q    <= pc;
            end else if (hit) begin
              inst_valid_q <= 1'b1;
              inst_err_q   <= 1'b0;
              inst_q       <= sel_word(buf_data_q, pc[2]);
              inst_pc_q    <= pc;
            end else begin
              req_pc_q  <= pc;
              no_fill_q <= 1'b0;
              state_q   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush) no_fill_q <= 1'b1;
          if (mem_req_ready) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (flush) no_fill_q <= 1'b1;
          if (mem_rsp_valid) begin
            inst_valid_q <= 1'b1;
            inst_err_q   <= mem_rsp_err;
            inst_q       <= mem_rsp_err ? 32'h0 : sel_word(mem_rsp_data, req_pc_q[2]);
            inst_pc_q    <= req_pc_q;
            // A flush seen at any point of the miss keeps this line out of the buffer.
            if (!mem_rsp_err && !flush && !no_fill_q) begin
              buf_valid_q <= 1'b1;
              buf_tag_q   <= req_pc_q[ADDR_W-1:3];
              buf_data_q  <= mem_rsp_data;
            end
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst_err      = inst_err_q;
  assign mem_req_valid = (state_q == S_REQ);
  assign fetch_stall   = (state_q != S_IDLE);
  assign mem_req_addr  = {req_pc_q[ADDR_W-1:3], 3'b000};

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_inst_fetch_resp;

  logic        clk = 1'b0;
  logic        rst, inst_ena, flush;
  logic [63:0] pc;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_valid, inst_err, fetch_stall;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_data;

  inst_fetch_resp #(.ADDR_W(64), .LINE_W(64)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_ena(inst_ena), .flush(flush),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_err(inst_err),
    .fetch_stall(fetch_stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Memory contents: one fixed line for the boot address, a hash elsewhere.
  function automatic logic [63:0] mem_line(input logic [63:0] a);
    if (a == 64'h8000_0000) return 64'h00000013_00100093;
    return {a[31:0] ^ 32'h1357_9BDF, a[31:0] * 32'h9E37_79B1};
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] line, input logic [63:0] a);
    return (a % 8 == 0) ? line[31:0] : line[63:32];
  endfunction

  // Memory responder knobs and state.
  int          ready_pct = 100, dly = 0, err_pct = 0, stray_pct = 0;
  bit          pend = 0;
  int          cnt = 0;
  logic [63:0] pend_addr = 0;

  always @(posedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      pend      = 1;
      cnt       = dly;
      pend_addr = mem_req_addr;
    end
  end

  // Behavioural model: transaction view of the responder.
  bit          m_busy = 0, m_granted = 0, m_nofill = 0, m_bv = 0;
  logic [63:0] m_req_pc = 0, m_tag = 0, m_line = 0;
  logic [31:0] e_inst = 0;
  logic [63:0] e_pc = 0;
  bit          e_vld = 0, e_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_granted = 0; m_nofill = 0; m_bv = 0; m_req_pc = 0;
      e_inst = 0; e_pc = 0; e_vld = 0; e_err = 0;
    end else begin
      e_vld = 0;
      if (!m_busy) begin
        if (inst_ena) begin
          if (pc % 4 != 0) begin
            e_vld = 1; e_err = 1; e_inst = 0; e_pc = pc;
          end else if (m_bv && !flush && m_tag == pc / 8) begin
            e_vld = 1; e_err = 0; e_inst = word_of(m_line, pc); e_pc = pc;
          end else begin
            m_busy = 1; m_granted = 0; m_req_pc = pc; m_nofill = 0;
          end
        end
        if (flush) m_bv = 0;
      end else begin
        if (flush) begin m_nofill = 1; m_bv = 0; end
        if (!m_granted) begin
          if (mem_req_ready) m_granted = 1;
        end else if (mem_rsp_valid) begin
          e_vld = 1; e_pc = m_req_pc; e_err = mem_rsp_err;
          e_inst = mem_rsp_err ? 32'h0 : word_of(mem_rsp_data, m_req_pc);
          if (!mem_rsp_err && !m_nofill) begin
            m_bv = 1; m_tag = m_req_pc / 8; m_line = mem_rsp_data;
          end
          m_busy = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, e_vld});
    chk("inst", {32'd0, inst}, {32'd0, e_inst});
    chk("inst_pc", inst_pc, e_pc);
    chk("inst_err", {63'd0, inst_err}, {63'd0, e_err});
    chk("mem_req_valid", {63'd0, mem_req_valid}, {63'd0, m_busy && !m_granted});
    chk("fetch_stall", {63'd0, fetch_stall}, {63'd0, m_busy});
    chk("mem_req_addr", mem_req_addr, m_req_pc & ~64'h7);
  endtask

  task automatic drive_mem();
    mem_req_ready = ($urandom_range(99) < ready_pct);
    mem_rsp_valid = 0;
    mem_rsp_err   = 0;
    mem_rsp_data  = {$urandom, $urandom};
    if (pend) begin
      if (cnt == 0) begin
        mem_rsp_valid = 1;
        mem_rsp_err   = ($urandom_range(99) < err_pct);
        if (!mem_rsp_err) mem_rsp_data = mem_line(pend_addr);
        pend = 0;
      end else cnt--;
    end else if ($urandom_range(99) < stray_pct) begin
      mem_rsp_valid = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    drive_mem();
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (inst_valid !== 1'b1 && k < 20) begin tick(); k++; end
    chk(name, {63'd0, inst_valid}, 64'd1);
  endtask

  task automatic fetch1(input logic [63:0] a);
    pc = a; inst_ena = 1; tick(); inst_ena = 0;
  endtask

  initial begin
    rst = 1; inst_ena = 0; flush = 0; pc = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_data = 0;
    tick(); tick();
    rst = 0;
    chk("rst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_stall", {63'd0, fetch_stall}, 64'd0);

    // Cold miss on the boot line.
    fetch1(64'h8000_0000);
    chk("miss_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("miss_req_addr", mem_req_addr, 64'h8000_0000);
    wait_valid("miss_resp_timeout");
    chk("miss_inst", {32'd0, inst}, 64'h0010_0093);
    chk("miss_inst_pc", inst_pc, 64'h8000_0000);

    // Sequential hit in the same line.
    fetch1(64'h8000_0004);
    chk("hit_valid", {63'd0, inst_valid}, 64'd1);
    chk("hit_inst", {32'd0, inst}, 64'h0000_0013);
    chk("hit_no_req", {63'd0, mem_req_valid}, 64'd0);

    // Memory back-pressure, then a PC redirect while waiting.
    ready_pct = 0; dly = 1;
    fetch1(64'h8000_0040);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("hold_req_addr", mem_req_addr, 64'h8000_0040);
      chk("hold_stall", {63'd0, fetch_stall}, 64'd1);
    end
    ready_pct = 100;
    tick(); tick();
    pc = 64'h8000_0100; inst_ena = 1;
    wait_valid("redirect_resp_timeout");
    chk("redirect_old_pc", inst_pc, 64'h8000_0040);
    tick();
    chk("redirect_new_req", {63'd0, mem_req_valid}, 64'd1);
    chk("redirect_new_addr", mem_req_addr, 64'h8000_0100);
    inst_ena = 0;
    wait_valid("redirect2_timeout");

    // Misaligned PC.
    fetch1(64'h8000_0002);
    chk("misal_err", {63'd0, inst_err}, 64'd1);
    chk("misal_inst", {32'd0, inst}, 64'd0);
    chk("misal_no_req", {63'd0, mem_req_valid}, 64'd0);

    // Bus error leaves the buffer untouched, so the refetch misses.
    err_pct = 100; dly = 0;
    fetch1(64'h8000_0200);
    wait_valid("buserr_timeout");
    chk("buserr_err", {63'd0, inst_err}, 64'd1);
    chk("buserr_inst", {32'd0, inst}, 64'd0);
    err_pct = 0;
    fetch1(64'h8000_0204);
    chk("buserr_refetch_miss", {63'd0, mem_req_valid}, 64'd1);
    wait_valid("buserr_refetch_timeout");

    // Flush during WAIT.
    dly = 2;
    fetch1(64'h8000_0008);
    tick();
    flush = 1; tick(); flush = 0;
    wait_valid("flush_resp_timeout");
    chk("flush_inst", {32'd0, inst}, {32'd0, mem_line(64'h8000_0008) & 64'hFFFF_FFFF});
    chk("flush_inst_pc", inst_pc, 64'h8000_0008);
    fetch1(64'h8000_000C);
    chk("flush_refetch_miss", {63'd0, mem_req_valid}, 64'd1);
    wait_valid("flush_refetch_timeout");

    // Reset in WAIT; the late response must be dropped.
    dly = 3;
    fetch1(64'h8000_0300);
    tick();
    rst = 1; tick(); rst = 0;
    chk("rstw_valid", {63'd0, inst_valid}, 64'd0);
    chk("rstw_inst", {32'd0, inst}, 64'd0);
    chk("rstw_req", {63'd0, mem_req_valid}, 64'd0);
    chk("rstw_stall", {63'd0, fetch_stall}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstw_late", {63'd0, inst_valid}, 64'd0);
    end

    // Randomized traffic.
    ready_pct = 60; err_pct = 10; stray_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      dly      = $urandom_range(3);
      rst      = ($urandom_range(199) == 0);
      flush    = ($urandom_range(99) < 5);
      inst_ena = ($urandom_range(99) < 60);
      if ($urandom_range(99) < 5) pc = {$urandom, $urandom};
      else pc = 64'h8000_0000 + 64'($urandom_range(7)) * 8 + 64'($urandom_range(1)) * 4;
      if ($urandom_range(99) < 5) pc = pc + 64'($urandom_range(3, 1));
      tick();
    end
    rst = 0; flush = 0; inst_ena = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
